rv32i_trace_buffer: RTL and testbench
=====================================

Name: rv32i_trace_buffer

Overview:
Post-core trace capture stage that consumes the rv32i core's per-cycle debug outputs: PC, instruction, ALU result and register data. It records one entry per retired PC into a circular buffer, with pre-trigger history and a programmable PC-match trigger. After capture it drains the entries word-serially over a valid/ready port for a bench or debug host. This replaces manual waveform and $display inspection with a bounded, checkable execution history.

Parameters:
DEPTH, 16, number of trace entries; power of 2, at least 4.
XLEN, 32, width of each captured field.
POST_TRIG, 8, entries captured after the trigger entry; must be ≤ DEPTH-1.

Ports:
clk  in  1  core clock; all state updates on its rising edge.
reset_n  in  1  asynchronous, active-low reset.
arm_i  in  1  1-cycle pulse; clears the buffer and enters ARMED (accepted in any state).
trig_en_i  in  1  1: trigger on PC match; 0: trigger on the first qualified sample.
trig_pc_i  in  XLEN  trigger PC value.
pc_i  in  XLEN  core pc_out.
instr_i  in  XLEN  core instr_out.
alu_i  in  XLEN  core alu_result_out.
reg_i  in  XLEN  core reg_data_out.
rd_valid_o  out  1  readout word valid.
rd_ready_i  in  1  readout word accept.
rd_data_o  out  XLEN  readout word.
rd_last_o  out  1  high on the 4th (final) word of an entry.
state_o  out  2  IDLE=0, ARMED=1, POST=2, DONE=3.
count_o  out  $clog2(DEPTH)+1  number of stored entries not yet drained.
overflow_o  out  1  sticky; set when ARMED overwrites the oldest entry.

Behaviour:
- Reset (async, reset_n=0): state IDLE, wr_ptr/rd_ptr/count/word_sel=0, overflow_o=0, rd_valid_o=0, rd_last_o=0, rd_data_o=0, last_pc register invalid. RAM contents don't care.
- Qualified sample: in ARMED or POST, a sample is taken in any cycle where last_pc is invalid or pc_i != last_pc.
  - The sample writes {pc_i, instr_i, alu_i, reg_i} at wr_ptr. wr_ptr then increments modulo DEPTH, and last_pc <= pc_i.
  - Repeated PC (stall or reset hold) is not recorded.
- IDLE: no capture, rd_valid_o=0. arm_i -> ARMED.
- arm_i, in any state: next cycle pointers=0, count=0, overflow=0, last_pc invalid, state ARMED. Same-cycle sample is ignored.
- ARMED behaviour per qualified sample:
  - If count<DEPTH, count increments.
  - Else count stays at DEPTH, rd_ptr increments and overflow_o is set (oldest entry discarded).
  - If trig_en_i=0, or pc_i==trig_pc_i, the sample is the trigger entry: post counter <= POST_TRIG, state -> POST. With POST_TRIG=0, state goes directly to DONE.
- POST: each qualified sample is stored with the same count/overflow rules and decrements the post counter. When the counter reaches 0 after a store, state -> DONE in the same edge.
- DONE: no capture.
  - rd_valid_o = (count!=0).
  - rd_data_o is selected by word_sel: 0 pc, 1 instr, 2 alu, 3 reg, taken from the entry at rd_ptr. rd_last_o = rd_valid_o && word_sel==3.
  - rd_data_o is combinational from the registered pointers, so it is stable while rd_valid_o && !rd_ready_i.
  - Transfer = rd_valid_o && rd_ready_i. word_sel increments on each transfer.
  - On the word-3 transfer: word_sel <= 0, rd_ptr++, count--. If count becomes 0, state -> IDLE.
- Ordering: drain is oldest-first. The trigger entry sits at position count-POST_TRIG (1-based) when no overflow occurred after the trigger.
- Reset mid-operation: any state returns to IDLE immediately; a partially drained entry is lost.

Decomposition:
- Package rv32i_trace_pkg holds:
  - trace_state_e enum (IDLE/ARMED/POST/DONE, 2-bit).
  - trace_entry_t packed struct {pc, instr, alu, rdata}.
  - word_sel_e enum (W_PC, W_INSTR, W_ALU, W_REG).
- Sub-module rv32i_trace_ram: DEPTH×(4·XLEN) register file with 1 synchronous write port and 1 asynchronous read port, no reset. The FSM, pointers and readout mux stay in the top.

Test Plan:
- Reset during POST with count=5 -> next cycle state_o=0, count_o=0, rd_valid_o=0, overflow_o=0; arm_i afterwards starts from empty.
- Arm, trig_en_i=0, POST_TRIG=8, pc 0x0,0x4,…,0x20 one per cycle -> DONE after the 9th sample. count_o=9, first word 0x00000000, rd_last_o on 4th word, 9th entry pc=0x20.
- DEPTH=16, trig_pc_i=0x50, pcs 0x0..0x70 step 4 (29 samples):
  - overflow_o=1 and count_o=16 in DONE.
  - Drained pcs are 0x34..0x70; the 8th entry is 0x50.
- pc held at 0x8 for 3 cycles, instr changing, trig_en_i=0 -> exactly one entry for 0x8, carrying the first cycle's fields.
- DONE with 2 entries, rd_ready_i toggling 1,0,1,0 -> words emitted in order pc, instr, alu, reg. rd_data_o is unchanged during stall cycles, rd_last_o is asserted only on the reg word, and state_o returns to 0 after the 8th transfer.
- arm_i pulse in DONE with count_o=5 -> next cycle state_o=1, count_o=0, rd_valid_o=0, overflow_o=0.

Source files
------------

// File: rtl/rv32i_trace_buffer_pkg.sv
// rtl/rv32i_trace_buffer_pkg.sv - shared types for the rv32i trace capture buffer
package rv32i_trace_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } trace_state_e;

    typedef enum logic [1:0] {
        W_PC    = 2'd0,
        W_INSTR = 2'd1,
        W_ALU   = 2'd2,
        W_REG   = 2'd3
    } word_sel_e;

    localparam int TRACE_XLEN = 32;

    // Field order matches the RAM word layout: pc in the top slice, rdata in the bottom.
    typedef struct packed {
        logic [TRACE_XLEN-1:0] pc;
        logic [TRACE_XLEN-1:0] instr;
        logic [TRACE_XLEN-1:0] alu;
        logic [TRACE_XLEN-1:0] rdata;
    } trace_entry_t;

endpackage

// File: rtl/rv32i_trace_buffer_if.sv
// rtl/rv32i_trace_buffer_if.sv - word-serial readout handshake of the trace buffer
interface rv32i_trace_buffer_if #(
    parameter int XLEN = 32
) ();
    logic            rd_valid_o;
    logic            rd_ready_i;
    logic [XLEN-1:0] rd_data_o;
    logic            rd_last_o;

    modport master (
        output rd_valid_o,
        output rd_data_o,
        output rd_last_o,
        input  rd_ready_i
    );

    modport slave (
        input  rd_valid_o,
        input  rd_data_o,
        input  rd_last_o,
        output rd_ready_i
    );
endinterface

// File: rtl/rv32i_trace_buffer_ram.sv
// rtl/rv32i_trace_buffer_ram.sv - trace entry register file, sync write / async read
module rv32i_trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/rv32i_trace_buffer.sv
// rtl/rv32i_trace_buffer.sv - circular PC trace capture with pre-trigger history and serial drain
module rv32i_trace_buffer
    import rv32i_trace_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int XLEN      = 32,
    parameter int POST_TRIG = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     arm_i,
    input  logic                     trig_en_i,
    input  logic [XLEN-1:0]          trig_pc_i,
    input  logic [XLEN-1:0]          pc_i,
    input  logic [XLEN-1:0]          instr_i,
    input  logic [XLEN-1:0]          alu_i,
    input  logic [XLEN-1:0]          reg_i,
    rv32i_trace_buffer_if.master     rd,
    output logic [1:0]               state_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    trace_state_e      state_q, state_d;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count, post_cnt;
    word_sel_e         word_sel;
    logic              overflow;
    logic              last_pc_vld;
    logic [XLEN-1:0]   last_pc;
    logic [4*XLEN-1:0] rd_entry;
    logic              sample, trig_hit, xfer, entry_done;

    // arm_i wins over a same-cycle sample so the fresh capture starts empty.
    assign sample     = (state_q == ARMED || state_q == POST) && !arm_i &&
                        (!last_pc_vld || pc_i != last_pc);
    assign trig_hit   = (state_q == ARMED) && (!trig_en_i || pc_i == trig_pc_i);
    assign xfer       = rd.rd_valid_o && rd.rd_ready_i;
    assign entry_done = xfer && (word_sel == W_REG);

    rv32i_trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (4*XLEN),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (sample),
        .waddr (wr_ptr),
        .wdata ({pc_i, instr_i, alu_i, reg_i}),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  state_d = IDLE;
            ARMED: if (sample && trig_hit) state_d = (POST_TRIG == 0) ? DONE : POST;
            POST:  if (sample && post_cnt == CW'(1)) state_d = DONE;
            DONE:  if (entry_done && count == CW'(1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (arm_i) begin
            state_d = ARMED;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            post_cnt    <= '0;
            word_sel    <= W_PC;
            overflow    <= 1'b0;
            last_pc_vld <= 1'b0;
            last_pc     <= '0;
        end else if (arm_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            post_cnt    <= '0;
            word_sel    <= W_PC;
            overflow    <= 1'b0;
            last_pc_vld <= 1'b0;
        end else begin
            if (sample) begin
                wr_ptr      <= wr_ptr + 1'b1;
                last_pc     <= pc_i;
                last_pc_vld <= 1'b1;
                if (count < CW'(DEPTH)) begin
                    count <= count + 1'b1;
                end else begin
                    rd_ptr   <= rd_ptr + 1'b1;
                    overflow <= 1'b1;
                end
                if (trig_hit) begin
                    post_cnt <= CW'(POST_TRIG);
                end else if (state_q == POST) begin
                    post_cnt <= post_cnt - 1'b1;
                end
            end
            if (xfer) begin
                word_sel <= word_sel_e'(word_sel + 2'd1);
            end
            if (entry_done) begin
                rd_ptr <= rd_ptr + 1'b1;
                count  <= count - 1'b1;
            end
        end
    end

    always_comb begin
        rd.rd_valid_o = (state_q == DONE) && (count != '0);
        rd.rd_data_o  = '0;
        rd.rd_last_o  = 1'b0;
        if (rd.rd_valid_o) begin
            rd.rd_last_o = (word_sel == W_REG);
            unique case (word_sel)
                W_PC:    rd.rd_data_o = rd_entry[4*XLEN-1 -: XLEN];
                W_INSTR: rd.rd_data_o = rd_entry[3*XLEN-1 -: XLEN];
                W_ALU:   rd.rd_data_o = rd_entry[2*XLEN-1 -: XLEN];
                W_REG:   rd.rd_data_o = rd_entry[XLEN-1:0];
                default: rd.rd_data_o = '0;
            endcase
        end
        state_o    = state_q;
        count_o    = count;
        overflow_o = overflow;
    end
endmodule

// File: tb/tb_rv32i_trace_buffer.sv
// tb/tb_rv32i_trace_buffer.sv - directed self-checking bench for rv32i_trace_buffer
module tb_rv32i_trace_buffer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        arm_i = 1'b0;
    logic        trig_en_i = 1'b0;
    logic [31:0] trig_pc_i = '0;
    logic [31:0] pc_i = '0, instr_i = '0, alu_i = '0, reg_i = '0;
    logic [1:0]  state_o;
    logic [4:0]  count_o;
    logic        overflow_o;
    int          total = 0;
    int          bad = 0;

    rv32i_trace_buffer_if #(.XLEN(32)) rd ();

    rv32i_trace_buffer #(.DEPTH(16), .XLEN(32), .POST_TRIG(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .arm_i      (arm_i),
        .trig_en_i  (trig_en_i),
        .trig_pc_i  (trig_pc_i),
        .pc_i       (pc_i),
        .instr_i    (instr_i),
        .alu_i      (alu_i),
        .reg_i      (reg_i),
        .rd         (rd),
        .state_o    (state_o),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_word(input logic [31:0] pc, input int w);
        case (w)
            0:       return pc;
            1:       return (pc << 7) | 32'h13;
            2:       return pc + 32'h100;
            default: return ~pc;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc);
        pc_i    = pc;
        instr_i = exp_word(pc, 1);
        alu_i   = exp_word(pc, 2);
        reg_i   = exp_word(pc, 3);
    endtask

    task automatic pulse_arm();
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        total++; if (state_o !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_o); end
        total++; if (count_o !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        total++; if (rd.rd_valid_o !== 1'b0 || rd.rd_last_o !== 1'b0) begin bad++; $display("FAIL reset_valid_last got=%b%b exp=00", rd.rd_valid_o, rd.rd_last_o); end
        total++; if (rd.rd_data_o !== 32'h0 || overflow_o !== 1'b0) begin bad++; $display("FAIL reset_data_ovf got=%h/%b exp=0/0", rd.rd_data_o, overflow_o); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_post();
        trig_en_i = 1'b0;
        pulse_arm();
        for (int i = 0; i < 5; i++) begin drive(32'(4*i)); tick(); end
        total++; if (state_o !== 2'd2 || count_o !== 5'd5) begin bad++; $display("FAIL midpost_pre got=%0d/%0d exp=2/5", state_o, count_o); end
        reset_n = 1'b0;
        tick();
        total++; if (state_o !== 2'd0) begin bad++; $display("FAIL midpost_state got=%0d exp=0", state_o); end
        total++; if (count_o !== 5'd0) begin bad++; $display("FAIL midpost_count got=%0d exp=0", count_o); end
        total++; if (rd.rd_valid_o !== 1'b0 || overflow_o !== 1'b0) begin bad++; $display("FAIL midpost_vld_ovf got=%b/%b exp=0/0", rd.rd_valid_o, overflow_o); end
        reset_n = 1'b1;
        tick();
        pulse_arm();
        total++; if (state_o !== 2'd1 || count_o !== 5'd0) begin bad++; $display("FAIL midpost_rearm got=%0d/%0d exp=1/0", state_o, count_o); end
        drive(32'h40);
        tick();
        total++; if (count_o !== 5'd1) begin bad++; $display("FAIL midpost_first_sample got=%0d exp=1", count_o); end
    endtask

    task automatic test_capture_basic();
        trig_en_i = 1'b0;
        pulse_arm();
        for (int i = 0; i < 9; i++) begin drive(32'(4*i)); tick(); end
        total++; if (state_o !== 2'd3) begin bad++; $display("FAIL basic_state got=%0d exp=3", state_o); end
        total++; if (count_o !== 5'd9) begin bad++; $display("FAIL basic_count got=%0d exp=9", count_o); end
        total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b exp=0", overflow_o); end
        rd.rd_ready_i = 1'b1;
        for (int n = 0; n < 36; n++) begin
            total++; if (rd.rd_valid_o !== 1'b1 || rd.rd_data_o !== exp_word(32'(4*(n/4)), n%4)) begin bad++; $display("FAIL basic_word%0d got=%b/%h exp=1/%h", n, rd.rd_valid_o, rd.rd_data_o, exp_word(32'(4*(n/4)), n%4)); end
            total++; if (rd.rd_last_o !== (n%4 == 3)) begin bad++; $display("FAIL basic_last%0d got=%b exp=%b", n, rd.rd_last_o, (n%4 == 3)); end
            tick();
        end
        rd.rd_ready_i = 1'b0;
        total++; if (state_o !== 2'd0 || count_o !== 5'd0 || rd.rd_valid_o !== 1'b0) begin bad++; $display("FAIL basic_end got=%0d/%0d/%b exp=0/0/0", state_o, count_o, rd.rd_valid_o); end
    endtask

    task automatic test_overflow();
        trig_en_i = 1'b1;
        trig_pc_i = 32'h50;
        pulse_arm();
        for (int i = 0; i < 29; i++) begin drive(32'(4*i)); tick(); end
        total++; if (state_o !== 2'd3) begin bad++; $display("FAIL ovf_state got=%0d exp=3", state_o); end
        total++; if (count_o !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", count_o); end
        total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow_o); end
        rd.rd_ready_i = 1'b1;
        for (int n = 0; n < 64; n++) begin
            total++; if (rd.rd_data_o !== exp_word(32'h34 + 32'(4*(n/4)), n%4)) begin bad++; $display("FAIL ovf_word%0d got=%h exp=%h", n, rd.rd_data_o, exp_word(32'h34 + 32'(4*(n/4)), n%4)); end
            if (n == 28) begin
                total++; if (rd.rd_data_o !== 32'h50) begin bad++; $display("FAIL ovf_trig_entry got=%h exp=00000050", rd.rd_data_o); end
            end
            tick();
        end
        rd.rd_ready_i = 1'b0;
        trig_en_i = 1'b0;
        total++; if (state_o !== 2'd0) begin bad++; $display("FAIL ovf_end got=%0d exp=0", state_o); end
    endtask

    task automatic test_stall();
        logic [31:0] e0 [4];
        e0 = '{32'h8, 32'hA, 32'h100, 32'h200};
        trig_en_i = 1'b0;
        pulse_arm();
        pc_i = 32'h8;
        for (int k = 0; k < 3; k++) begin
            instr_i = 32'hA + 32'(k);
            alu_i   = 32'h100 + 32'(k);
            reg_i   = 32'h200 + 32'(k);
            tick();
        end
        for (int i = 0; i < 8; i++) begin drive(32'hC + 32'(4*i)); tick(); end
        total++; if (state_o !== 2'd3 || count_o !== 5'd9) begin bad++; $display("FAIL stall_done got=%0d/%0d exp=3/9", state_o, count_o); end
        rd.rd_ready_i = 1'b1;
        for (int n = 0; n < 8; n++) begin
            logic [31:0] exp;
            exp = (n < 4) ? e0[n] : exp_word(32'hC, n-4);
            total++; if (rd.rd_data_o !== exp) begin bad++; $display("FAIL stall_word%0d got=%h exp=%h", n, rd.rd_data_o, exp); end
            tick();
        end
        for (int n = 0; n < 8; n++) tick();
        rd.rd_ready_i = 1'b0;
        total++; if (count_o !== 5'd5) begin bad++; $display("FAIL stall_remaining got=%0d exp=5", count_o); end
    endtask

    task automatic test_arm_in_done();
        total++; if (state_o !== 2'd3 || count_o !== 5'd5) begin bad++; $display("FAIL armdone_pre got=%0d/%0d exp=3/5", state_o, count_o); end
        pulse_arm();
        total++; if (state_o !== 2'd1 || count_o !== 5'd0) begin bad++; $display("FAIL armdone_state got=%0d/%0d exp=1/0", state_o, count_o); end
        total++; if (rd.rd_valid_o !== 1'b0 || overflow_o !== 1'b0) begin bad++; $display("FAIL armdone_vld_ovf got=%b/%b exp=0/0", rd.rd_valid_o, overflow_o); end
    endtask

    task automatic test_back_to_back();
        int          n;
        logic        rdy;
        logic [31:0] hold;
        logic [31:0] exp;
        trig_en_i = 1'b0;
        pulse_arm();
        for (int i = 0; i < 9; i++) begin drive(32'h100 + 32'(4*i)); tick(); end
        rd.rd_ready_i = 1'b1;
        for (int i = 0; i < 28; i++) tick();
        total++; if (count_o !== 5'd2) begin bad++; $display("FAIL b2b_pre_count got=%0d exp=2", count_o); end
        n = 0;
        for (int cyc = 0; cyc < 40 && n < 8; cyc++) begin
            rdy = (cyc % 2 == 0);
            rd.rd_ready_i = rdy;
            exp = exp_word(32'h100 + 32'(4*(7 + n/4)), n%4);
            total++; if (rd.rd_valid_o !== 1'b1 || rd.rd_data_o !== exp) begin bad++; $display("FAIL b2b_word%0d got=%b/%h exp=1/%h", n, rd.rd_valid_o, rd.rd_data_o, exp); end
            total++; if (rd.rd_last_o !== (n%4 == 3)) begin bad++; $display("FAIL b2b_last%0d got=%b exp=%b", n, rd.rd_last_o, (n%4 == 3)); end
            hold = rd.rd_data_o;
            tick();
            if (!rdy) begin
                total++; if (rd.rd_data_o !== hold || rd.rd_valid_o !== 1'b1) begin bad++; $display("FAIL b2b_stall%0d got=%b/%h exp=1/%h", n, rd.rd_valid_o, rd.rd_data_o, hold); end
            end else begin
                n++;
            end
        end
        rd.rd_ready_i = 1'b0;
        total++; if (n !== 8) begin bad++; $display("FAIL b2b_transfers got=%0d exp=8", n); end
        total++; if (state_o !== 2'd0) begin bad++; $display("FAIL b2b_end_state got=%0d exp=0", state_o); end
    endtask

    initial begin
        rd.rd_ready_i = 1'b0;
        test_reset();
        test_reset_mid_post();
        test_capture_basic();
        test_overflow();
        test_stall();
        test_arm_in_done();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
